// File: rtl/data_sram_like_slave.sv
// -----------------------------------------------------------------------------
// data_sram_like_slave
//
// Responder end of the data-side SRAM-like bus (req / addr_ok / data_ok). It
// models data memory behind the CPU for simulation and FPGA bring-up. Each
// accepted request enters an in-order pending queue and is answered with a
// one-cycle data_ok pulse exactly LATENCY cycles after the accept edge.
//
// Parameters
//   ADDR_W  : word-index width; memory holds 2**ADDR_W 32-bit words.
//   LATENCY : cycles from the accept edge to the data_ok pulse (1..7).
//   DEPTH   : maximum outstanding requests (1..8); DEPTH >= LATENCY gives
//             one accept per cycle.
//
// Ports
//   clk               : clock, all state updates on posedge.
//   reset             : synchronous, active-high reset.
//   data_sram_req     : request valid.
//   data_sram_wr      : 1 = write, 0 = read.
//   data_sram_size    : access size; informational only, wstrb governs writes.
//   data_sram_wstrb   : byte-lane write enables.
//   data_sram_addr    : byte address; word index is addr[ADDR_W+1:2].
//   data_sram_wdata   : write data.
//   data_sram_addr_ok : request accepted this cycle when high together with req.
//   data_sram_data_ok : one-cycle response pulse.
//   data_sram_rdata   : read data, valid while data_ok is high (0 for writes).
//
// Optional feature
//   DSRAM_RAND_STALL_EN : when defined, a 16-bit Fibonacci LFSR (taps
//   16,14,13,11, seed 16'hACE1) gates addr_ok with ~lfsr[0] to produce
//   pseudo-random accept stalls. Response latency is unaffected.
// -----------------------------------------------------------------------------
module data_sram_like_slave #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int              PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CNT_W      = $clog2(DEPTH + 1);
  localparam logic [2:0]      RETIRE_AGE = 3'(LATENCY - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  // Backing store and request decode
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       mem_rd;
  logic              accept;
  logic              stall;

  // Pending queue: one {rdata, age} pair per slot, circular via head/tail
  logic [31:0]      ent_rdata_q [DEPTH];
  logic [31:0]      ent_rdata_d [DEPTH];
  logic [2:0]       ent_age_q   [DEPTH];
  logic [2:0]       ent_age_d   [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;

  // Registered response outputs
  logic             data_ok_q, data_ok_d;
  logic [31:0]      rdata_q, rdata_d;

  // Size and the address bits outside the word index carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2],
                         data_sram_addr[1:0]};

`ifdef DSRAM_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // A full queue blocks a new request even if the head retires this cycle.
  assign data_sram_addr_ok = ~reset & (count_q != FULL) & ~stall;
  assign accept            = data_sram_req & data_sram_addr_ok;
  assign idx               = data_sram_addr[ADDR_W+1:2];
  assign mem_rd            = mem[idx];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Ages count edges since acceptance with the accept edge itself as 1, so the
  // head retires on the edge where its age reaches LATENCY-1 and data_ok then
  // appears LATENCY cycles after the accept edge. Entries all share one
  // latency and are kept in order, so only the head can ever be due.
  always_comb begin
    int off;
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    off         = 0;
    ent_rdata_d = ent_rdata_q;
    ent_age_d   = ent_age_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    retire      = 1'b0;
    data_ok_d   = 1'b0;
    rdata_d     = '0;

    if (LATENCY == 1) begin
      // The response is registered straight off the accept edge; nothing waits.
      data_ok_d = accept;
      rdata_d   = (accept && !data_sram_wr) ? mem_rd : '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        off = i - int'(head_q);
        if (off < 0) off = off + DEPTH;
        if (off < int'(count_q)) ent_age_d[i] = ent_age_q[i] + 3'd1;
      end

      retire = (count_q != '0) && (ent_age_q[head_q] == RETIRE_AGE);
      if (retire) begin
        data_ok_d         = 1'b1;
        rdata_d           = ent_rdata_q[head_q];
        ent_age_d[head_q] = '0;
        head_d            = ptr_inc(head_q);
      end

      // The tail slot is free whenever accept is possible, so it never
      // collides with the head being retired.
      if (accept) begin
        ent_rdata_d[tail_q] = data_sram_wr ? 32'h0 : mem_rd;
        ent_age_d[tail_q]   = 3'd1;
        tail_d              = ptr_inc(tail_q);
      end

      count_d = count_q + CNT_W'(accept) - CNT_W'(retire);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < DEPTH; i++) ent_age_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      ent_age_q <= ent_age_d;
    end
  end

  // NOTE: data storage (queue payload and memory) has no reset; validity comes
  // from count/age, and memory contents must survive a reset.
  always_ff @(posedge clk) begin
    ent_rdata_q <= ent_rdata_d;
  end

  // Byte-lane writes land on the accept edge; a read accepted on that same
  // edge is impossible, so a read one cycle later sees the new data.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_like_slave.sv
// -----------------------------------------------------------------------------
// tb_data_sram_like_slave
//
// Three responders with different LATENCY/DEPTH share a clock and reset; each
// has its own request inputs. A reference model tracks, per responder, the
// words it holds and a list of outstanding responses with the edge at which
// each is due (accept edge + LATENCY - 1). From that list follow the expected
// addr_ok (outstanding count below DEPTH, reset low), data_ok and rdata.
// -----------------------------------------------------------------------------
module tb_data_sram_like_slave;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req     [NI];
  logic        wr      [NI];
  logic [1:0]  size    [NI];
  logic [3:0]  wstrb   [NI];
  logic [31:0] addr    [NI];
  logic [31:0] wdata   [NI];
  logic        addr_ok [NI];
  logic        data_ok [NI];
  logic [31:0] rdata   [NI];

  data_sram_like_slave #(.ADDR_W(10), .LATENCY(2), .DEPTH(4)) u_l2d4 (
    .clk(clk), .reset(reset),
    .data_sram_req(req[0]), .data_sram_wr(wr[0]), .data_sram_size(size[0]),
    .data_sram_wstrb(wstrb[0]), .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
    .data_sram_addr_ok(addr_ok[0]), .data_sram_data_ok(data_ok[0]),
    .data_sram_rdata(rdata[0])
  );

  data_sram_like_slave #(.ADDR_W(10), .LATENCY(3), .DEPTH(2)) u_l3d2 (
    .clk(clk), .reset(reset),
    .data_sram_req(req[1]), .data_sram_wr(wr[1]), .data_sram_size(size[1]),
    .data_sram_wstrb(wstrb[1]), .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
    .data_sram_addr_ok(addr_ok[1]), .data_sram_data_ok(data_ok[1]),
    .data_sram_rdata(rdata[1])
  );

  data_sram_like_slave #(.ADDR_W(10), .LATENCY(4), .DEPTH(4)) u_l4d4 (
    .clk(clk), .reset(reset),
    .data_sram_req(req[2]), .data_sram_wr(wr[2]), .data_sram_size(size[2]),
    .data_sram_wstrb(wstrb[2]), .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]),
    .data_sram_addr_ok(addr_ok[2]), .data_sram_data_ok(data_ok[2]),
    .data_sram_rdata(rdata[2])
  );

  // Reference model state
  typedef struct {
    int          k;
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       pend [$];
  logic [31:0] mem_m [NI][16];
  int          edge_n = 0;
  bit          acc [NI];
  logic [31:0] last_rdata [NI];
  int          resp_cnt [NI];
  int          checks = 0;
  int          errors = 0;

  function automatic int lat(input int k);
    case (k)
      0:       return 2;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int dep(input int k);
    return (k == 1) ? 2 : 4;
  endfunction

  function automatic int outstanding(input int k);
    int n = 0;
    foreach (pend[j]) if (pend[j].k == k) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check addr_ok before the edge, update the model at the edge,
  // check data_ok/rdata at the following negedge. Inputs change only between
  // steps, at the negedge.
  task automatic step();
    logic        exp_ok;
    logic [31:0] old;
    int          w;
    int          j;
    resp_t       r;
    #1;
    for (int k = 0; k < NI; k++) begin
      exp_ok = !reset && (outstanding(k) != dep(k));
`ifdef DSRAM_RAND_STALL_EN
      check($sformatf("addr_ok_only_when_room[%0d]@%0d", k, edge_n),
            32'(addr_ok[k] && !exp_ok), 32'h0);
      acc[k] = req[k] && addr_ok[k];
`else
      check($sformatf("addr_ok[%0d]@%0d", k, edge_n), 32'(addr_ok[k]), 32'(exp_ok));
      acc[k] = req[k] && exp_ok;
`endif
    end
    @(posedge clk);
    edge_n++;
    if (reset) begin
      pend.delete();
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (acc[k]) begin
          w   = int'(addr[k][5:2]);
          old = mem_m[k][w];
          if (wr[k]) begin
            for (int b = 0; b < 4; b++)
              if (wstrb[k][b]) mem_m[k][w][8*b +: 8] = wdata[k][8*b +: 8];
          end
          r.k    = k;
          r.due  = edge_n + lat(k) - 1;
          r.data = wr[k] ? 32'h0 : old;
          pend.push_back(r);
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      j = -1;
      foreach (pend[i]) if (j < 0 && pend[i].k == k) j = i;
      if (data_ok[k] === 1'b1) begin
        last_rdata[k] = rdata[k];
        resp_cnt[k]++;
      end
      if (j >= 0 && pend[j].due == edge_n) begin
        check($sformatf("data_ok[%0d]@%0d", k, edge_n), 32'(data_ok[k]), 32'h1);
        check($sformatf("rdata[%0d]@%0d", k, edge_n), rdata[k], pend[j].data);
        pend.delete(j);
      end else begin
        check($sformatf("data_ok[%0d]@%0d", k, edge_n), 32'(data_ok[k]), 32'h0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold one request on responder k until it is accepted (bounded).
  task automatic issue(input int k, input bit w, input int word,
                       input logic [31:0] d, input logic [3:0] s, output int waited);
    logic [31:0] a;
    a       = $urandom();
    a[11:6] = '0;
    a[5:2]  = word[3:0];
    req[k]   = 1'b1;
    wr[k]    = w;
    size[k]  = 2'd2;
    addr[k]  = a;
    wdata[k] = d;
    wstrb[k] = s;
    waited   = 0;
    for (int n = 0; n < 32; n++) begin
      step();
      if (acc[k]) break;
      waited++;
    end
    check($sformatf("accepted[%0d] word %0d", k, word), 32'(acc[k]), 32'h1);
    req[k] = 1'b0;
  endtask

  initial begin
    int          waited;
    int          total;
    int          base;
    logic [31:0] a;

    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'd2; wstrb[k] = 4'h0;
      addr[k] = '0; wdata[k] = '0; last_rdata[k] = '0; resp_cnt[k] = 0;
      for (int i = 0; i < 16; i++) mem_m[k][i] = '0;
    end

    // Reset: addr_ok low throughout, outputs cleared.
    idle(3);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_rdata[%0d]", k), rdata[k], 32'h0);
      check($sformatf("reset_data_ok[%0d]", k), 32'(data_ok[k]), 32'h0);
    end
    reset = 1'b0;

    // Preload words 0..15 of every responder with zero.
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 16; i++) issue(k, 1'b1, i, 32'h0, 4'hF, waited);
    idle(6);

    // Full-word write to 0x10 then read it on the next cycle.
    issue(0, 1'b1, 4, 32'h12345678, 4'hF, waited);
`ifndef DSRAM_RAND_STALL_EN
    check("wr_0x10_no_wait", 32'(waited), 32'h0);
`endif
    issue(0, 1'b0, 4, 32'h0, 4'h0, waited);
`ifndef DSRAM_RAND_STALL_EN
    check("rd_0x10_no_wait", 32'(waited), 32'h0);
`endif
    idle(4);
    check("rd_0x10_data", last_rdata[0], 32'h12345678);

    // Partial write with wstrb 0101 into a zeroed word.
    issue(0, 1'b1, 5, 32'hAABBCCDD, 4'b0101, waited);
    issue(0, 1'b0, 5, 32'h0, 4'h0, waited);
    idle(4);
    check("partial_wstrb_data", last_rdata[0], 32'h00BB00DD);

    // LATENCY=3, DEPTH=2: six reads with req held; two accepts per three cycles.
    total = 0;
    base  = resp_cnt[1];
    for (int i = 0; i < 6; i++) begin
      issue(1, 1'b0, i, 32'h0, 4'h0, waited);
      total += waited;
    end
    idle(6);
`ifndef DSRAM_RAND_STALL_EN
    check("l3d2_stall_cycles", 32'(total), 32'h2);
`endif
    check("l3d2_resp_count", 32'(resp_cnt[1] - base), 32'h6);

    // LATENCY=4, DEPTH=4: ten back-to-back reads, pointers wrap.
    total = 0;
    base  = resp_cnt[2];
    for (int i = 0; i < 10; i++) begin
      issue(2, 1'b0, i, 32'h0, 4'h0, waited);
      total += waited;
    end
    idle(6);
`ifndef DSRAM_RAND_STALL_EN
    check("l4d4_stall_cycles", 32'(total), 32'h0);
`endif
    check("l4d4_resp_count", 32'(resp_cnt[2] - base), 32'hA);

    // Reset with three reads pending: nothing answers afterwards.
    base = resp_cnt[2];
    for (int i = 0; i < 3; i++) issue(2, 1'b0, i, 32'h0, 4'h0, waited);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(8);
    check("reset_drops_pending", 32'(resp_cnt[2] - base), 32'h0);
    issue(0, 1'b0, 4, 32'h0, 4'h0, waited);
    idle(4);
    check("mem_kept_over_reset", last_rdata[0], 32'h12345678);

    // Random traffic on all responders.
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < NI; k++) begin
        a        = $urandom();
        a[11:6]  = '0;
        req[k]   = ($urandom_range(0, 9) < 7);
        wr[k]    = 1'($urandom_range(0, 1));
        size[k]  = 2'($urandom_range(0, 2));
        wstrb[k] = 4'($urandom());
        wdata[k] = $urandom();
        addr[k]  = a;
      end
      step();
    end
    for (int k = 0; k < NI; k++) req[k] = 1'b0;
    idle(8);

    // Read every word back; rdata is compared against the model memory.
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 16; i++) issue(k, 1'b0, i, 32'h0, 4'h0, waited);
    idle(8);
    check("all_responses_drained", 32'(pend.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
